// File: rtl/monitor_seq_pkg.sv
// rtl/monitor_seq_pkg.sv - shared types, defaults and rotate helper for the one-hot ring monitor
package monitor_seq_pkg;

    // Monitor phases: hunting for a legal word, confirming the progression, locked flywheel
    typedef enum logic [1:0] {
        BUSCA   = 2'd0,
        SINC    = 2'd1,
        TRAVADO = 2'd2
    } estado_t;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_LOCK_COUNT = 3;
    localparam int DEF_ERR_LIMIT  = 2;
    localparam int DEF_CNT_W      = 8;

    // Widest ring the rotate helper handles; callers cast down to their own width
    localparam int ROT_MAX_W = 64;

    // Rotate-left by one within the low 'width' bits; the top bit of the ring wraps to bit 0
    function automatic logic [ROT_MAX_W-1:0] rot_esq(input logic [ROT_MAX_W-1:0] word,
                                                     input int unsigned          width);
        logic [ROT_MAX_W-1:0] mask;
        mask = (width >= ROT_MAX_W) ? {ROT_MAX_W{1'b1}}
                                    : ((ROT_MAX_W'(1) << width) - ROT_MAX_W'(1));
        rot_esq = ((word << 1) | (word >> (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/onehot_para_bin.sv
// rtl/onehot_para_bin.sv - combinational one-hot to binary index encoder with legality flag
//
// Ports:
//   palavra  in   WIDTH   word to decode
//   indice   out  IDX_W   position of the set bit (meaningful only when legal is 1)
//   legal    out  1       exactly one bit of palavra is set
module onehot_para_bin #(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] palavra,
    output logic [IDX_W-1:0] indice,
    output logic             legal
);

    int unsigned n_uns;

    always_comb begin
        n_uns  = 0;
        indice = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (palavra[i]) begin
                n_uns  = n_uns + 1;
                indice = IDX_W'(i);
            end
        end
        legal = (n_uns == 1);
    end

endmodule

// File: rtl/monitor_seq_onehot.sv
// rtl/monitor_seq_onehot.sv - receive-side lock/flywheel checker for the one-hot ring sequence
//
// Optional feature macro: MONITOR_SEQ_ERRO_STICKY_EN (adds limpa_erro / erro_sticky)
//
// Ports:
//   clk            in   1      rising-edge clock
//   reset          in   1      asynchronous active-high reset
//   valid_in       in   1      sample strobe
//   dado_in        in   WIDTH  observed word
//   indice         out  IDX_W  binary index of the last legal sample
//   indice_valido  out  1      pulse: legal sample accepted
//   travado        out  1      level: monitor locked
//   erro           out  1      pulse: mismatch while locked
//   voltas         out  CNT_W  completed rings while locked (wraps)
//   volta_pulso    out  1      pulse: voltas incremented
//   limpa_erro     in   1      (macro only) clear erro_sticky
//   erro_sticky    out  1      (macro only) latched erro
module monitor_seq_onehot
    import monitor_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int ERR_LIMIT  = DEF_ERR_LIMIT,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] dado_in,
`ifdef MONITOR_SEQ_ERRO_STICKY_EN
    input  logic             limpa_erro,
    output logic             erro_sticky,
`endif
    output logic [IDX_W-1:0] indice,
    output logic             indice_valido,
    output logic             travado,
    output logic             erro,
    output logic [CNT_W-1:0] voltas,
    output logic             volta_pulso
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int EC_W = $clog2(ERR_LIMIT + 1);

    estado_t          estado, estado_nxt;
    logic [WIDTH-1:0] ref_word, ref_nxt;
    logic [WIDTH-1:0] esperado;
    logic [MC_W-1:0]  match_cnt, match_nxt;
    logic [EC_W-1:0]  err_cnt, err_nxt;
    logic [IDX_W-1:0] indice_nxt;
    logic             indice_valido_nxt;
    logic             erro_nxt;
    logic [CNT_W-1:0] voltas_nxt;
    logic             volta_pulso_nxt;

    logic [IDX_W-1:0] dec_indice;
    logic             dec_legal;
    logic             casa;

    onehot_para_bin #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_dec (
        .palavra (dado_in),
        .indice  (dec_indice),
        .legal   (dec_legal)
    );

    // Reference is zero after reset, so nothing matches until BUSCA loads a legal word
    assign esperado = WIDTH'(rot_esq(ROT_MAX_W'(ref_word), WIDTH));
    assign casa     = (dado_in == esperado);
    assign travado  = (estado == TRAVADO);

    always_comb begin
        estado_nxt        = estado;
        ref_nxt           = ref_word;
        match_nxt         = match_cnt;
        err_nxt           = err_cnt;
        indice_nxt        = indice;
        indice_valido_nxt = 1'b0;
        erro_nxt          = 1'b0;
        voltas_nxt        = voltas;
        volta_pulso_nxt   = 1'b0;

        if (valid_in) begin
            if (dec_legal) begin
                indice_nxt        = dec_indice;
                indice_valido_nxt = 1'b1;
            end

            unique case (estado)
                BUSCA: begin
                    if (dec_legal) begin
                        ref_nxt    = dado_in;
                        match_nxt  = '0;
                        estado_nxt = SINC;
                    end
                end

                SINC: begin
                    if (casa) begin
                        ref_nxt = dado_in;
                        if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                            match_nxt  = '0;
                            err_nxt    = '0;
                            estado_nxt = TRAVADO;
                        end else begin
                            match_nxt = match_cnt + MC_W'(1);
                        end
                    end else if (dec_legal) begin
                        // A legal but out-of-order word restarts confirmation from that word
                        ref_nxt   = dado_in;
                        match_nxt = '0;
                    end else begin
                        match_nxt  = '0;
                        estado_nxt = BUSCA;
                    end
                end

                TRAVADO: begin
                    // Flywheel: the reference advances on its own, so one bad word
                    // does not shift the phase we expect next
                    ref_nxt = esperado;
                    if (casa) begin
                        err_nxt = '0;
                        if (esperado[0]) begin
                            voltas_nxt      = voltas + CNT_W'(1);
                            volta_pulso_nxt = 1'b1;
                        end
                    end else begin
                        erro_nxt = 1'b1;
                        if (err_cnt == EC_W'(ERR_LIMIT - 1)) begin
                            err_nxt    = '0;
                            estado_nxt = BUSCA;
                        end else begin
                            err_nxt = err_cnt + EC_W'(1);
                        end
                    end
                end

                default: begin
                    estado_nxt = BUSCA;
                    ref_nxt    = '0;
                    match_nxt  = '0;
                    err_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado        <= BUSCA;
            ref_word      <= '0;
            match_cnt     <= '0;
            err_cnt       <= '0;
            indice        <= '0;
            indice_valido <= 1'b0;
            erro          <= 1'b0;
            voltas        <= '0;
            volta_pulso   <= 1'b0;
        end else begin
            estado        <= estado_nxt;
            ref_word      <= ref_nxt;
            match_cnt     <= match_nxt;
            err_cnt       <= err_nxt;
            indice        <= indice_nxt;
            indice_valido <= indice_valido_nxt;
            erro          <= erro_nxt;
            voltas        <= voltas_nxt;
            volta_pulso   <= volta_pulso_nxt;
        end
    end

`ifdef MONITOR_SEQ_ERRO_STICKY_EN
    // Set takes priority over clear so an error in the clearing cycle is never lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            erro_sticky <= 1'b0;
        end else if (erro_nxt) begin
            erro_sticky <= 1'b1;
        end else if (limpa_erro) begin
            erro_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_monitor_seq_onehot.sv
// tb/tb_monitor_seq_onehot.sv - scoreboard bench for monitor_seq_onehot
module tb_monitor_seq_onehot;

    localparam int W    = 4;
    localparam int LOCK = 3;
    localparam int ELIM = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_in = 1'b0;
    logic [3:0] dado_in = 4'd0;
    logic [1:0] indice;
    logic       indice_valido, travado, erro, volta_pulso;
    logic [7:0] voltas;
`ifdef MONITOR_SEQ_ERRO_STICKY_EN
    logic       limpa_erro = 1'b0;
    logic       erro_sticky;
`endif

    monitor_seq_onehot dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .dado_in       (dado_in),
`ifdef MONITOR_SEQ_ERRO_STICKY_EN
        .limpa_erro    (limpa_erro),
        .erro_sticky   (erro_sticky),
`endif
        .indice        (indice),
        .indice_valido (indice_valido),
        .travado       (travado),
        .erro          (erro),
        .voltas        (voltas),
        .volta_pulso   (volta_pulso)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ind;
        logic       iv;
        logic       tr;
        logic       er;
        logic [7:0] vo;
        logic       vp;
        logic       st;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: tracks the ring by index arithmetic rather than words
    int         m_st = 0;
    int         m_ref = 0;
    int         m_mc = 0;
    int         m_ec = 0;
    logic [1:0] m_ind = 0;
    logic [7:0] m_vo = 0;
    logic       m_st_bit = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ref = 0; m_mc = 0; m_ec = 0; m_ind = 0; m_vo = 0; m_st_bit = 0;
    endtask

    function automatic exp_t model_step(input logic v, input logic [3:0] d, input logic clr);
        exp_t e;
        int   pos;
        int   nxt;
        logic leg;
        e.iv = 0; e.er = 0; e.vp = 0;
        leg = ($countones(d) == 1);
        pos = 0;
        for (int i = 0; i < W; i++) if (d[i]) pos = i;
        if (v) begin
            if (leg) begin
                m_ind = 2'(pos);
                e.iv  = 1;
            end
            nxt = (m_ref + 1) % W;
            case (m_st)
                0: if (leg) begin m_ref = pos; m_mc = 0; m_st = 1; end
                1: begin
                    if (leg && pos == nxt) begin
                        m_ref = pos; m_mc++;
                        if (m_mc == LOCK) begin m_st = 2; m_mc = 0; m_ec = 0; end
                    end else if (leg) begin
                        m_ref = pos; m_mc = 0;
                    end else begin
                        m_st = 0; m_mc = 0;
                    end
                end
                default: begin
                    m_ref = nxt;
                    if (leg && pos == nxt) begin
                        m_ec = 0;
                        if (pos == 0) begin m_vo = m_vo + 8'd1; e.vp = 1; end
                    end else begin
                        e.er = 1; m_ec++;
                        if (m_ec == ELIM) begin m_st = 0; m_ec = 0; end
                    end
                end
            endcase
        end
        if (e.er) m_st_bit = 1;
        else if (clr) m_st_bit = 0;
        e.ind = m_ind;
        e.tr  = (m_st == 2);
        e.vo  = m_vo;
        e.st  = m_st_bit;
        return e;
    endfunction

    task automatic step(input logic v, input logic [3:0] d, input logic clr);
        exp_t e;
        @(negedge clk);
        valid_in = v;
        dado_in  = d;
`ifdef MONITOR_SEQ_ERRO_STICKY_EN
        limpa_erro = clr;
`endif
        exp_q.push_back(model_step(v, d, clr));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("indice", 32'(indice), 32'(e.ind));
            check("indice_valido", 32'(indice_valido), 32'(e.iv));
            check("travado", 32'(travado), 32'(e.tr));
            check("erro", 32'(erro), 32'(e.er));
            check("voltas", 32'(voltas), 32'(e.vo));
            check("volta_pulso", 32'(volta_pulso), 32'(e.vp));
`ifdef MONITOR_SEQ_ERRO_STICKY_EN
            check("erro_sticky", 32'(erro_sticky), 32'(e.st));
`endif
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_indice"}, 32'(indice), 0);
        check({tag, "_iv"}, 32'(indice_valido), 0);
        check({tag, "_travado"}, 32'(travado), 0);
        check({tag, "_erro"}, 32'(erro), 0);
        check({tag, "_voltas"}, 32'(voltas), 0);
        check({tag, "_vp"}, 32'(volta_pulso), 0);
`ifdef MONITOR_SEQ_ERRO_STICKY_EN
        check({tag, "_sticky"}, 32'(erro_sticky), 0);
`endif
    endtask

    initial begin
        logic [3:0] seq[4];
        logic [3:0] w;
        seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd4; seq[3] = 4'd8;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Lock-in: travado rises after the third matching transition
        for (int i = 0; i < 4; i++) step(1, seq[i], 0);
        check("lock_travado", 32'(travado), 1);
        check("lock_indice", 32'(indice), 3);

        // Ring counting, then run to expected=1
        for (int i = 0; i < 5; i++) step(1, seq[i % 4], 0);
        check("ring_voltas", 32'(voltas), 2);
        for (int i = 1; i < 4; i++) step(1, seq[i], 0);

        // Single error on an illegal word; flywheel keeps the phase
        step(1, 4'd1, 0);
        step(1, 4'd5, 0);
        check("single_erro", 32'(erro), 1);
        check("single_travado", 32'(travado), 1);
        step(1, 4'd4, 0);
        check("single_recover_erro", 32'(erro), 0);

        // Advance to expected=2, then two consecutive errors drop lock
        step(1, 4'd8, 0);
        step(1, 4'd1, 0);
        step(1, 4'd8, 0);
        check("loss_erro1_travado", 32'(travado), 1);
        step(1, 4'd8, 0);
        check("loss_erro2", 32'(erro), 1);
        check("loss_travado", 32'(travado), 0);

        // Strobe gaps do not count as samples
        step(1, 4'd1, 0);
        for (int i = 0; i < 3; i++) step(0, 4'd1, 0);
        step(1, 4'd2, 0);
        step(1, 4'd4, 0);
        check("gap_not_yet", 32'(travado), 0);
        step(1, 4'd8, 0);
        check("gap_lock", 32'(travado), 1);

`ifdef MONITOR_SEQ_ERRO_STICKY_EN
        // Sticky: set, set-beats-clear, clear alone (expected=1 here)
        step(1, 4'd2, 0);
        step(1, 4'd2, 0);
        check("sticky_set", 32'(erro_sticky), 1);
        step(1, 4'd1, 0);
        step(1, 4'd4, 1);
        check("sticky_set_wins", 32'(erro_sticky), 1);
        step(1, 4'd4, 1);
        check("sticky_clear", 32'(erro_sticky), 0);
`endif

        // Mixed stimulus: mostly in-order words, some gaps, junk and skips
        w = 4'd1;
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 13) begin
                step(1, w, (r == 3));
                w = {w[2:0], w[3]};
            end else if (r < 15) begin
                step(0, 4'($urandom), 0);
            end else if (r < 17) begin
                step(1, 4'($urandom), 0);
            end else begin
                w = seq[$urandom_range(0, 3)];
                step(1, w, 0);
                w = {w[2:0], w[3]};
            end
        end

        // Relock, then asynchronous reset between edges clears everything at once
        for (int i = 0; i < 4; i++) step(1, seq[i], 0);
        step(1, 4'd1, 0);
        check("prereset_travado", 32'(travado), 1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1, 4'd2, 0);
        step(0, 4'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
